// File: rtl/hilo_mdu_pkg.sv
// Shared MDU definitions: op codes, FSM states and the HI/LO write bundle
// that heads ex_to_id_bus ({hi_we, lo_we, hi, lo}, 66 bits).
package hilo_mdu_pkg;

  localparam logic [2:0] MDU_OP_NONE  = 3'd0;
  localparam logic [2:0] MDU_OP_MULT  = 3'd1;
  localparam logic [2:0] MDU_OP_MULTU = 3'd2;
  localparam logic [2:0] MDU_OP_DIV   = 3'd3;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

  localparam int MDU_TO_HILO_WD = 66;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_to_hilo_t;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_mdu_div_core.sv
// Unsigned radix-2 iterative datapath: restoring divide or shift-add multiply,
// one step per cycle while step=1; last_step flags the final iteration.
module mdu_div_core #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic        step,
  input  logic        mul,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        last_step
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [32:0] shifted;
  logic [33:0] diff;
  logic [32:0] sum;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;

    // {rem, quo} acts as one 64-bit shift register for both operations.
    shifted = {rem_q, quo_q[31]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : 33'd0);

    if (start) begin
      rem_d = 32'd0;
      quo_d = a_mag;
      dvs_d = b_mag;
      cnt_d = '0;
    end else if (step) begin
      if (mul) begin
        rem_d = sum[32:1];
        quo_d = {sum[0], quo_q[31:1]};
      end else if (!diff[33]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
    end

    if (flush) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= 32'd0;
      quo_q <= 32'd0;
      dvs_q <= 32'd0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo       = quo_q;
  assign rem       = rem_q;
  assign last_step = (cnt_q == CW'(DIV_CYCLES - 1));

endmodule

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit writing HI/LO. Divide takes 34 cycles (stallreq 33);
// MT*/MULT are same-cycle unless MDU_ITER_MUL_EN makes MULT iterate like divide.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_e state_q, state_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic mul_q, mul_d;
  logic dz_q, dz_d;

  logic         is_signed;
  logic         is_mul;
  logic         launch;
  logic         core_start;
  logic         core_step;
  logic [31:0]  core_quo;
  logic [31:0]  core_rem;
  logic         core_last;
  logic [63:0]  prod_fix;
  mdu_to_hilo_t res;

  assign is_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  assign is_mul    = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);

`ifndef MDU_ITER_MUL_EN
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  assign ext_a = {{32{is_signed & src_a[31]}}, src_a};
  assign ext_b = {{32{is_signed & src_b[31]}}, src_b};
  assign prod  = ext_a * ext_b;
`endif

  mdu_div_core #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .flush     (flush),
    .step      (core_step),
    .mul       (mul_q),
    .a_mag     (mag32(src_a, is_signed)),
    .b_mag     (mag32(src_b, is_signed)),
    .quo       (core_quo),
    .rem       (core_rem),
    .last_step (core_last)
  );

  always_comb begin
    state_d    = state_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    mul_d      = mul_q;
    dz_d       = dz_q;
    launch     = 1'b0;
    core_start = 1'b0;
    core_step  = 1'b0;
    stallreq   = 1'b0;
    res        = '0;
    prod_fix   = qneg_q ? -{core_rem, core_quo} : {core_rem, core_quo};

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op)
            MDU_OP_MTHI: begin
              res.hi_we = 1'b1;
              res.hi    = src_a;
            end
            MDU_OP_MTLO: begin
              res.lo_we = 1'b1;
              res.lo    = src_a;
            end
            MDU_OP_MULT, MDU_OP_MULTU: begin
`ifdef MDU_ITER_MUL_EN
              launch = 1'b1;
`else
              res.hi_we = 1'b1;
              res.lo_we = 1'b1;
              res.hi    = prod[63:32];
              res.lo    = prod[31:0];
`endif
            end
            MDU_OP_DIV, MDU_OP_DIVU: launch = 1'b1;
            default: ;
          endcase
        end
        if (launch) begin
          stallreq   = 1'b1;
          core_start = 1'b1;
          state_d    = BUSY;
          qneg_d     = is_signed & (src_a[31] ^ src_b[31]);
          rneg_d     = is_signed & src_a[31];
          mul_d      = is_mul;
          dz_d       = !is_mul && (src_b == 32'd0);
        end
      end
      BUSY: begin
        stallreq  = 1'b1;
        core_step = 1'b1;
        if (core_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        res.hi_we = 1'b1;
        res.lo_we = 1'b1;
        state_d   = IDLE;
        if (mul_q) begin
          res.hi = prod_fix[63:32];
          res.lo = prod_fix[31:0];
        end else begin
          // Divide by zero leaves the unsigned quotient all-ones; keep it unsigned.
          res.lo = dz_q ? 32'hFFFF_FFFF : (qneg_q ? -core_quo : core_quo);
          res.hi = rneg_q ? -core_rem : core_rem;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush || rst) begin
      stallreq   = 1'b0;
      res        = '0;
      core_start = 1'b0;
      core_step  = 1'b0;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      mul_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      mul_q   <= mul_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_we = res.hi_we;
  assign lo_we = res.lo_we;
  assign hi_o  = res.hi;
  assign lo_o  = res.lo;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: single-cycle op table plus divide, flush and reset sequences.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stallreq;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [66:0] obs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hilo_mdu dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .stallreq (stallreq),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  assign obs = {stallreq, hi_we, lo_we, hi_o, lo_o};

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [66:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_div(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int stalls;
    bit done;
    bit bad_we;
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    stalls = 0; done = 1'b0; bad_we = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (stallreq) begin
        stalls++;
        if (hi_we || lo_we) bad_we = 1'b1;
        @(negedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    chk({name, " completes"}, 67'(done), 67'd1);
    chk({name, " stall cycles"}, 67'(stalls), 67'd33);
    chk({name, " write while stalled"}, 67'(bad_we), 67'd0);
    chk({name, " result"}, obs, {1'b0, 1'b1, 1'b1, ehi, elo});
    op_valid = 1'b0; op = MDU_OP_NONE;
  endtask

  initial begin
    vecs[0] = '{"mult -1*2",     MDU_OP_MULT,  32'hFFFFFFFF, 32'd2,        {3'b011, 32'hFFFFFFFF, 32'hFFFFFFFE}};
    vecs[1] = '{"multu ffff*2",  MDU_OP_MULTU, 32'hFFFFFFFF, 32'd2,        {3'b011, 32'h00000001, 32'hFFFFFFFE}};
    vecs[2] = '{"mult -3*5",     MDU_OP_MULT,  32'hFFFFFFFD, 32'd5,        {3'b011, 32'hFFFFFFFF, 32'hFFFFFFF1}};
    vecs[3] = '{"mult min*min",  MDU_OP_MULT,  32'h80000000, 32'h80000000, {3'b011, 32'h40000000, 32'h00000000}};
    vecs[4] = '{"multu 2^16^2",  MDU_OP_MULTU, 32'h00010000, 32'h00010000, {3'b011, 32'h00000001, 32'h00000000}};
    vecs[5] = '{"mthi",          MDU_OP_MTHI,  32'h00001234, 32'h0000BEEF, {3'b010, 32'h00001234, 32'h00000000}};
    vecs[6] = '{"mtlo",          MDU_OP_MTLO,  32'h00005678, 32'h0000BEEF, {3'b001, 32'h00000000, 32'h00005678}};
    vecs[7] = '{"op none",       MDU_OP_NONE,  32'h11111111, 32'h22222222, {3'b000, 32'h00000000, 32'h00000000}};
    vecs[8] = '{"op invalid 7",  3'd7,         32'h11111111, 32'h22222222, {3'b000, 32'h00000000, 32'h00000000}};

    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = MDU_OP_NONE; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset outputs", obs, 67'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      op_valid = 1'b1; op = vecs[i].op; src_a = vecs[i].a; src_b = vecs[i].b;
      #1;
      chk(vecs[i].name, obs, vecs[i].exp);
    end
    op_valid = 1'b0; op = MDU_OP_NONE;

    run_div("div -7/2",   MDU_OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_div("divu 100/7", MDU_OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14);
    run_div("divu 5/0",   MDU_OP_DIVU, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    run_div("div 7/-2",   MDU_OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    run_div("div -5/0",   MDU_OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);

    @(negedge clk);
    #1;
    chk("idle after done", obs, 67'd0);

    @(negedge clk);
    op_valid = 1'b1; op = MDU_OP_DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush cycle stall/we", 67'({stallreq, hi_we, lo_we}), 67'd0);
    run_div("divu 9/3 after flush", MDU_OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3);

    @(negedge clk);
    op_valid = 1'b1; op = MDU_OP_DIV; src_a = 32'd100; src_b = 32'd7;
    repeat (5) @(negedge clk);
    rst = 1'b1; op_valid = 1'b0; op = MDU_OP_NONE;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after mid-div reset", obs, 67'd0);
    @(negedge clk);
    #1;
    chk("idle after reset", obs, 67'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
